// File: rtl/gzip_trailer_checker_if.sv
// gzip_trailer_checker_if: payload/trailer byte streams into the checker and
// the check results coming back out. The master drives the streams and the
// slave (the checker) drives the results.
interface gzip_trailer_checker_if;
    logic        clear_in;
    logic [7:0]  data_in;
    logic        data_valid_in;
    logic [7:0]  trailer_in;
    logic        trailer_valid_in;
    logic [31:0] crc32_calc_out;
    logic [31:0] isize_calc_out;
    logic        check_done_out;
    logic        crc_ok_out;
    logic        isize_ok_out;
    logic        proto_err_out;
    logic        timeout_err_out;
    logic [15:0] err_count_out;

    modport master (
        output clear_in, data_in, data_valid_in, trailer_in, trailer_valid_in,
        input  crc32_calc_out, isize_calc_out, check_done_out, crc_ok_out,
               isize_ok_out, proto_err_out, timeout_err_out, err_count_out
    );

    modport slave (
        input  clear_in, data_in, data_valid_in, trailer_in, trailer_valid_in,
        output crc32_calc_out, isize_calc_out, check_done_out, crc_ok_out,
               isize_ok_out, proto_err_out, timeout_err_out, err_count_out
    );
endinterface

// File: rtl/gzip_trailer_checker.sv
// gzip_trailer_checker: runs CRC-32 (reflected, poly 0xEDB88320) and a byte
// count over the inflated payload, then collects the 8-byte GZIP trailer
// (CRC32 LE, ISIZE LE) and reports whether both match.
// Optional feature macro: GZIP_TRAILER_ERR_CNT_EN enables a saturating
// counter of failed frames on err_count_out; otherwise err_count_out is 0.
module gzip_trailer_checker #(
    parameter int ISIZE_CHECK     = 1,
    parameter int TRAILER_TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gzip_trailer_checker_if.slave bus
);

    localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] TMO_LIMIT    = 32'(TRAILER_TIMEOUT);
    localparam logic        TMO_EN       = (TRAILER_TIMEOUT > 0);
    localparam logic        ISIZE_CHK_EN = (ISIZE_CHECK != 0);

    typedef enum logic [1:0] {
        ST_PAYLOAD = 2'd0,
        ST_TRAILER = 2'd1,
        ST_CHECK   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // One byte of reflected CRC-32, eight bit-steps unrolled.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_t      state_r;
    logic [31:0] crc_r;
    logic [31:0] crc_out_r;
    logic [31:0] isize_r;
    logic [63:0] trailer_r;
    logic [2:0]  idx_r;
    logic [31:0] idle_cnt_r;
    logic        done_r;
    logic        crc_ok_r;
    logic        isize_ok_r;
    logic        proto_r;
    logic        tmo_r;

    logic [31:0] crc_next_s;
    logic [31:0] idle_next_s;
    logic        timeout_hit_s;
    logic        crc_match_s;
    logic        isize_ok_s;

    // Next CRC, idle count and trailer comparison results.
    always_comb begin
        crc_next_s    = crc32_byte(crc_r, bus.data_in);
        idle_next_s   = idle_cnt_r + 32'd1;
        crc_match_s   = (trailer_r[31:0] == ~crc_r);
        timeout_hit_s = 1'b0;
        isize_ok_s    = 1'b1;
        if (TMO_EN) begin
            timeout_hit_s = (idle_next_s >= TMO_LIMIT);
        end else begin
            timeout_hit_s = 1'b0;
        end
        if (ISIZE_CHK_EN) begin
            isize_ok_s = (trailer_r[63:32] == isize_r);
        end else begin
            isize_ok_s = 1'b1;
        end
    end

    // Frame state machine with all result registers; clear_in restarts a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_PAYLOAD;
            crc_r      <= CRC_INIT;
            crc_out_r  <= 32'h00000000;
            isize_r    <= 32'h00000000;
            trailer_r  <= 64'h0000000000000000;
            idx_r      <= 3'd0;
            idle_cnt_r <= 32'h00000000;
            done_r     <= 1'b0;
            crc_ok_r   <= 1'b0;
            isize_ok_r <= 1'b0;
            proto_r    <= 1'b0;
            tmo_r      <= 1'b0;
        end else if (bus.clear_in) begin
            state_r    <= ST_PAYLOAD;
            crc_r      <= CRC_INIT;
            crc_out_r  <= 32'h00000000;
            isize_r    <= 32'h00000000;
            trailer_r  <= 64'h0000000000000000;
            idx_r      <= 3'd0;
            idle_cnt_r <= 32'h00000000;
            done_r     <= 1'b0;
            crc_ok_r   <= 1'b0;
            isize_ok_r <= 1'b0;
            proto_r    <= 1'b0;
            tmo_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_PAYLOAD: begin
                    if (bus.data_valid_in && bus.trailer_valid_in) begin
                        proto_r    <= 1'b1;
                        done_r     <= 1'b1;
                        crc_ok_r   <= 1'b0;
                        isize_ok_r <= 1'b0;
                        state_r    <= ST_DONE;
                    end else if (bus.data_valid_in) begin
                        crc_r     <= crc_next_s;
                        crc_out_r <= ~crc_next_s;
                        isize_r   <= isize_r + 32'd1;
                    end else if (bus.trailer_valid_in) begin
                        // First trailer byte may arrive with no payload (empty frame).
                        trailer_r[7:0] <= bus.trailer_in;
                        idx_r          <= 3'd1;
                        idle_cnt_r     <= 32'h00000000;
                        state_r        <= ST_TRAILER;
                    end
                end
                ST_TRAILER: begin
                    if (bus.data_valid_in) begin
                        // Payload after the trailer started: byte is dropped.
                        proto_r    <= 1'b1;
                        done_r     <= 1'b1;
                        crc_ok_r   <= 1'b0;
                        isize_ok_r <= 1'b0;
                        state_r    <= ST_DONE;
                    end else if (bus.trailer_valid_in) begin
                        trailer_r[{idx_r, 3'b000} +: 8] <= bus.trailer_in;
                        idle_cnt_r <= 32'h00000000;
                        idx_r      <= idx_r + 3'd1;
                        if (idx_r == 3'd7) begin
                            state_r <= ST_CHECK;
                        end
                    end else if (timeout_hit_s) begin
                        tmo_r      <= 1'b1;
                        done_r     <= 1'b1;
                        crc_ok_r   <= 1'b0;
                        isize_ok_r <= 1'b0;
                        state_r    <= ST_DONE;
                    end else begin
                        idle_cnt_r <= idle_next_s;
                    end
                end
                ST_CHECK: begin
                    if (bus.data_valid_in && bus.trailer_valid_in) begin
                        proto_r    <= 1'b1;
                        done_r     <= 1'b1;
                        crc_ok_r   <= 1'b0;
                        isize_ok_r <= 1'b0;
                        state_r    <= ST_DONE;
                    end else begin
                        // A lone stray trailer byte here is simply ignored.
                        crc_ok_r   <= crc_match_s;
                        isize_ok_r <= isize_ok_s;
                        done_r     <= 1'b1;
                        state_r    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_PAYLOAD;
                end
            endcase
        end
    end

    assign bus.crc32_calc_out  = crc_out_r;
    assign bus.isize_calc_out  = isize_r;
    assign bus.check_done_out  = done_r;
    assign bus.crc_ok_out      = crc_ok_r;
    assign bus.isize_ok_out    = isize_ok_r;
    assign bus.proto_err_out   = proto_r;
    assign bus.timeout_err_out = tmo_r;

`ifdef GZIP_TRAILER_ERR_CNT_EN
    logic [15:0] err_cnt_r;
    logic        done_d_r;

    // Count frames that reach DONE without both checks passing; survives clear_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= 16'h0000;
            done_d_r  <= 1'b0;
        end else begin
            done_d_r <= done_r;
            if (done_r && !done_d_r && !(crc_ok_r && isize_ok_r) &&
                (err_cnt_r != 16'hFFFF)) begin
                err_cnt_r <= err_cnt_r + 16'd1;
            end
        end
    end

    assign bus.err_count_out = err_cnt_r;
`else
    assign bus.err_count_out = 16'h0000;
`endif

endmodule

// File: tb/tb_gzip_trailer_checker.sv
// tb_gzip_trailer_checker: table-driven frame vectors plus hand sequences for
// protocol errors, trailer timeout, reset mid-frame and clear_in priority.
module tb_gzip_trailer_checker;

    logic clk = 1'b0;
    logic rst_n;

    // Free-running clock.
    always #5 clk = ~clk;

    gzip_trailer_checker_if bus ();

    gzip_trailer_checker #(
        .ISIZE_CHECK     (1),
        .TRAILER_TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors  = 0;
    int checks  = 0;
    int exp_err = 0;

    string digits = "0123456789";
    string fox    = "The quick brown fox jumps over the lazy dog";

    // mode: 0 digits, 1 zeros, 2 0xFF, 3 ramp i, 4 fox
    typedef struct {
        int          mode;
        int          len;
        logic [63:0] trailer;
        logic [31:0] exp_crc;
        logic [31:0] exp_isize;
        logic        exp_crc_ok;
        logic        exp_isize_ok;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [7:0] pbyte(input int mode, input int i);
        logic [7:0] b;
        case (mode)
            0:       b = digits[i];
            1:       b = 8'h00;
            2:       b = 8'hFF;
            3:       b = i[7:0];
            4:       b = fox[i];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_clear();
        bus.clear_in = 1'b1;
        tick();
        bus.clear_in = 1'b0;
    endtask

    task automatic send_payload(input int mode, input int len);
        for (int i = 0; i < len; i++) begin
            bus.data_in       = pbyte(mode, i);
            bus.data_valid_in = 1'b1;
            tick();
        end
        bus.data_valid_in = 1'b0;
    endtask

    task automatic send_trailer(input logic [63:0] t, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            bus.trailer_in       = t[k*8 +: 8];
            bus.trailer_valid_in = 1'b1;
            tick();
        end
        bus.trailer_valid_in = 1'b0;
    endtask

    task automatic note_fail_frame();
`ifdef GZIP_TRAILER_ERR_CNT_EN
        if (exp_err < 65535) exp_err++;
`endif
    endtask

    task automatic chk_err_cnt(input string name);
        chk(name, {16'h0000, bus.err_count_out}, exp_err);
    endtask

    // Stimulus and checking.
    initial begin
        bus.clear_in         = 1'b0;
        bus.data_in          = 8'h00;
        bus.data_valid_in    = 1'b0;
        bus.trailer_in       = 8'h00;
        bus.trailer_valid_in = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_crc",   bus.crc32_calc_out, 32'h00000000);
        chk("rst_isize", bus.isize_calc_out, 32'h00000000);
        chk("rst_done",  {31'd0, bus.check_done_out}, 32'd0);
        chk("rst_flags", {28'd0, bus.crc_ok_out, bus.isize_ok_out,
                          bus.proto_err_out, bus.timeout_err_out}, 32'd0);
        chk_err_cnt("rst_errcnt");
        tick();
        rst_n = 1'b1;
        tick();

        vecs[0] = '{0, 10, 64'h0000000A_A684C7C6, 32'hA684C7C6, 32'd10, 1'b1, 1'b1};
        vecs[1] = '{1, 32, 64'h00000020_190A55AD, 32'h190A55AD, 32'd32, 1'b1, 1'b1};
        vecs[2] = '{2, 32, 64'h00000020_FE6CAB0B, 32'hFF6CAB0B, 32'd32, 1'b0, 1'b1};
        vecs[3] = '{1, 0,  64'h00000000_00000000, 32'h00000000, 32'd0,  1'b1, 1'b1};
        vecs[4] = '{3, 32, 64'h00000021_91267E8A, 32'h91267E8A, 32'd32, 1'b1, 1'b0};

        for (int v = 0; v < 5; v++) begin
            do_clear();
            chk($sformatf("v%0d_clr_done", v), {31'd0, bus.check_done_out}, 32'd0);
            chk($sformatf("v%0d_clr_isize", v), bus.isize_calc_out, 32'd0);
            send_payload(vecs[v].mode, vecs[v].len);
            send_trailer(vecs[v].trailer, 0, 7);
            chk($sformatf("v%0d_done_early", v), {31'd0, bus.check_done_out}, 32'd0);
            tick();
            chk($sformatf("v%0d_done", v), {31'd0, bus.check_done_out}, 32'd1);
            chk($sformatf("v%0d_crc", v), bus.crc32_calc_out, vecs[v].exp_crc);
            chk($sformatf("v%0d_isize", v), bus.isize_calc_out, vecs[v].exp_isize);
            chk($sformatf("v%0d_crc_ok", v), {31'd0, bus.crc_ok_out}, {31'd0, vecs[v].exp_crc_ok});
            chk($sformatf("v%0d_isize_ok", v), {31'd0, bus.isize_ok_out}, {31'd0, vecs[v].exp_isize_ok});
            chk($sformatf("v%0d_errs", v), {30'd0, bus.proto_err_out, bus.timeout_err_out}, 32'd0);
            if (!(vecs[v].exp_crc_ok && vecs[v].exp_isize_ok)) note_fail_frame();
            tick();
            chk_err_cnt($sformatf("v%0d_errcnt", v));
        end

        // Payload byte arriving mid-trailer.
        do_clear();
        send_payload(4, 43);
        send_trailer(64'h0, 0, 2);
        bus.data_in = 8'h41;
        bus.data_valid_in = 1'b1;
        tick();
        bus.data_valid_in = 1'b0;
        chk("fox_proto", {31'd0, bus.proto_err_out}, 32'd1);
        chk("fox_done",  {31'd0, bus.check_done_out}, 32'd1);
        chk("fox_ok",    {30'd0, bus.crc_ok_out, bus.isize_ok_out}, 32'd0);
        chk("fox_crc",   bus.crc32_calc_out, 32'h414FA339);
        chk("fox_isize", bus.isize_calc_out, 32'd43);
        note_fail_frame();
        tick();
        // Inputs in DONE are ignored.
        bus.data_valid_in = 1'b1;
        bus.trailer_valid_in = 1'b1;
        tick();
        tick();
        bus.data_valid_in = 1'b0;
        bus.trailer_valid_in = 1'b0;
        chk("done_hold_isize", bus.isize_calc_out, 32'd43);
        chk("done_hold_flags", {30'd0, bus.proto_err_out, bus.timeout_err_out}, 32'd2);
        chk_err_cnt("fox_errcnt");

        // Data and trailer valid together in PAYLOAD.
        do_clear();
        send_payload(0, 2);
        bus.data_valid_in = 1'b1;
        bus.trailer_valid_in = 1'b1;
        tick();
        bus.data_valid_in = 1'b0;
        bus.trailer_valid_in = 1'b0;
        chk("both_proto", {31'd0, bus.proto_err_out}, 32'd1);
        chk("both_done",  {31'd0, bus.check_done_out}, 32'd1);
        chk("both_isize", bus.isize_calc_out, 32'd2);
        chk("both_ok",    {30'd0, bus.crc_ok_out, bus.isize_ok_out}, 32'd0);
        note_fail_frame();
        tick();
        chk_err_cnt("both_errcnt");

        // Trailer idle timeout after 2 bytes.
        do_clear();
        send_trailer(64'h0, 0, 1);
        repeat (15) tick();
        chk("tmo15_err",  {31'd0, bus.timeout_err_out}, 32'd0);
        chk("tmo15_done", {31'd0, bus.check_done_out}, 32'd0);
        tick();
        chk("tmo16_err",  {31'd0, bus.timeout_err_out}, 32'd1);
        chk("tmo16_done", {31'd0, bus.check_done_out}, 32'd1);
        chk("tmo16_flags", {29'd0, bus.crc_ok_out, bus.isize_ok_out, bus.proto_err_out}, 32'd0);
        note_fail_frame();
        tick();
        chk_err_cnt("tmo_errcnt");

        // 15 idle cycles is still within budget.
        do_clear();
        send_payload(0, 10);
        send_trailer(64'h0000000A_A684C7C6, 0, 1);
        repeat (15) tick();
        send_trailer(64'h0000000A_A684C7C6, 2, 7);
        tick();
        chk("gap_done", {31'd0, bus.check_done_out}, 32'd1);
        chk("gap_tmo",  {31'd0, bus.timeout_err_out}, 32'd0);
        chk("gap_ok",   {30'd0, bus.crc_ok_out, bus.isize_ok_out}, 32'd3);

        // Reset mid-frame discards the partial frame.
        do_clear();
        send_payload(4, 5);
        #2 rst_n = 1'b0;
        #1;
        exp_err = 0;
        chk("midrst_crc",   bus.crc32_calc_out, 32'h00000000);
        chk("midrst_isize", bus.isize_calc_out, 32'h00000000);
        chk_err_cnt("midrst_errcnt");
        tick();
        rst_n = 1'b1;
        send_payload(0, 10);
        send_trailer(64'h0000000A_A684C7C6, 0, 7);
        tick();
        chk("postrst_crc", bus.crc32_calc_out, 32'hA684C7C6);
        chk("postrst_ok",  {30'd0, bus.crc_ok_out, bus.isize_ok_out}, 32'd3);

        // clear_in wins over data_valid_in.
        bus.clear_in = 1'b1;
        bus.data_in = 8'h55;
        bus.data_valid_in = 1'b1;
        repeat (3) tick();
        chk("clrhold_isize", bus.isize_calc_out, 32'd0);
        chk("clrhold_crc",   bus.crc32_calc_out, 32'd0);
        bus.clear_in = 1'b0;
        bus.data_valid_in = 1'b0;
        tick();
        chk("clrhold_isize2", bus.isize_calc_out, 32'd0);
        chk_err_cnt("final_errcnt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
